cspi_mst: RTL and testbench

//  Byte-oriented control-SPI master in the clk_sys domain; the initiator end of the control SPI link.

---
 rtl/cspi_mst_pkg.sv | 28 ++
 rtl/cspi_mst_tick.sv | 31 +++
 rtl/cspi_mst.sv | 244 ++++++++++++++++++++++++
 tb/tb_cspi_mst.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cspi_mst_pkg.sv
// Shared definitions for the control-SPI master: FSM state encoding,
// SPI idle line levels and counter sizing helpers.
package cspi_mst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LEAD     = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_GAP      = 3'd3,
    ST_WAIT_CMD = 3'd4,
    ST_TRAIL    = 3'd5,
    ST_CSN_HOLD = 3'd6
  } cspi_state_e;

  localparam logic CSN_IDLE  = 1'b1;
  localparam logic SCK_IDLE  = 1'b0;
  localparam logic MOSI_IDLE = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold any value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cspi_mst_tick.sv
// Loadable down-counter shared by every timed state of the SPI master.
// Loading N-1 on entry gives a state that lasts exactly N cycles; tc is
// high while the count sits at zero, where it saturates.
module cspi_mst_tick #(
  parameter int W = 8
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_r;

  // Reload on request, otherwise count down and hold at zero.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {W{1'b0}}) begin
      cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/cspi_mst.sv
// Control-SPI master, mode 0, MSB first, sck idle low.
// Optional build macro CSPI_MST_WD_EN: abort a burst that stalls in
// WAIT_CMD for WD_LIMIT cycles (wd_abort pulse, csn then released).
// The shared interval counter is always sized for the largest interval,
// watchdog included, so the non-watchdog build keeps the same timing path.
module cspi_mst
  import cspi_mst_pkg::*;
#(
  parameter int HALF_DIV = 50,
  parameter int LEAD     = 50,
  parameter int BYTE_GAP = 200,
  parameter int CSN_GAP  = 100,
  parameter int WD_LIMIT = 1000000
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [7:0] cmd_data,
  input  logic       cmd_last,
  input  logic       cmd_vld,
  output logic       cmd_rdy,
  output logic [7:0] rsp_q,
  output logic       rsp_qvld,
  output logic       busy,
  output logic       wd_abort,
  output logic       spi_csn,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int MAX_CNT = max2(max2(max2(HALF_DIV, LEAD), max2(BYTE_GAP, CSN_GAP)), WD_LIMIT);
  localparam int CNT_W   = cnt_width(MAX_CNT);

  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] LEAD_LD = CNT_W'(LEAD - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(BYTE_GAP - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(CSN_GAP - 1);
  localparam logic [CNT_W-1:0] WD_LD   = CNT_W'(WD_LIMIT - 1);

  cspi_state_e      state_r;
  logic [7:0]       tx_r;
  logic [7:0]       rx_r;
  logic [3:0]       edge_r;
  logic             last_r;
  logic             miso_meta_r;
  logic             miso_sync_r;
  logic             accept_s;
  logic             tick_load_s;
  logic [CNT_W-1:0] tick_val_s;
  logic             tick_tc_s;

  assign cmd_rdy  = (state_r == ST_IDLE) || (state_r == ST_WAIT_CMD);
  assign busy     = (state_r != ST_IDLE);
  assign accept_s = cmd_vld & cmd_rdy;

  cspi_mst_tick #(.W(CNT_W)) u_tick (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .load     (tick_load_s),
    .load_val (tick_val_s),
    .tc       (tick_tc_s)
  );

  // Two-flop synchroniser for the asynchronous miso line.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      miso_meta_r <= 1'b0;
      miso_sync_r <= 1'b0;
    end else begin
      miso_meta_r <= spi_miso;
      miso_sync_r <= miso_meta_r;
    end
  end

  // Reload the interval counter on every state change and every sck toggle.
  always_comb begin
    tick_load_s = 1'b0;
    tick_val_s  = {CNT_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          tick_load_s = 1'b1;
          tick_val_s  = LEAD_LD;
        end else begin
          tick_load_s = 1'b0;
        end
      end
      ST_LEAD: begin
        if (tick_tc_s) begin
          tick_load_s = 1'b1;
          tick_val_s  = HALF_LD;
        end else begin
          tick_load_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (tick_tc_s) begin
          tick_load_s = 1'b1;
          if (spi_sck && (edge_r == 4'd15)) begin
            tick_val_s = last_r ? HALF_LD : GAP_LD;
          end else begin
            tick_val_s = HALF_LD;
          end
        end else begin
          tick_load_s = 1'b0;
        end
      end
      ST_GAP: begin
        if (tick_tc_s) begin
          tick_load_s = 1'b1;
          tick_val_s  = WD_LD;
        end else begin
          tick_load_s = 1'b0;
        end
      end
      ST_WAIT_CMD: begin
        if (accept_s) begin
          tick_load_s = 1'b1;
          tick_val_s  = HALF_LD;
        end
`ifdef CSPI_MST_WD_EN
        else if (tick_tc_s) begin
          tick_load_s = 1'b1;
          tick_val_s  = HALF_LD;
        end
`endif
        else begin
          tick_load_s = 1'b0;
        end
      end
      ST_TRAIL: begin
        if (tick_tc_s) begin
          tick_load_s = 1'b1;
          tick_val_s  = HOLD_LD;
        end else begin
          tick_load_s = 1'b0;
        end
      end
      ST_CSN_HOLD: begin
        if (tick_tc_s) begin
          tick_load_s = 1'b1;
          tick_val_s  = {CNT_W{1'b0}};
        end else begin
          tick_load_s = 1'b0;
        end
      end
      default: begin
        tick_load_s = 1'b1;
        tick_val_s  = {CNT_W{1'b0}};
      end
    endcase
  end

  // Transfer FSM with registered SPI pins and response outputs.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      spi_csn  <= CSN_IDLE;
      spi_sck  <= SCK_IDLE;
      spi_mosi <= MOSI_IDLE;
      rsp_q    <= 8'h00;
      rsp_qvld <= 1'b0;
      wd_abort <= 1'b0;
      tx_r     <= 8'h00;
      rx_r     <= 8'h00;
      edge_r   <= 4'd0;
      last_r   <= 1'b0;
    end else begin
      rsp_qvld <= 1'b0;
      wd_abort <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            tx_r     <= {cmd_data[6:0], 1'b0};
            spi_mosi <= cmd_data[7];
            spi_csn  <= 1'b0;
            last_r   <= cmd_last;
            edge_r   <= 4'd0;
            state_r  <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (tick_tc_s) state_r <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick_tc_s) begin
            spi_sck <= ~spi_sck;
            edge_r  <= edge_r + 4'd1;
            if (!spi_sck) begin
              rx_r <= {rx_r[6:0], miso_sync_r};
            end else if (edge_r != 4'd15) begin
              spi_mosi <= tx_r[7];
              tx_r     <= {tx_r[6:0], 1'b0};
            end else begin
              rsp_q    <= rx_r;
              rsp_qvld <= 1'b1;
              if (last_r) begin
                spi_mosi <= MOSI_IDLE;
                state_r  <= ST_TRAIL;
              end else begin
                state_r  <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (tick_tc_s) state_r <= ST_WAIT_CMD;
        end
        ST_WAIT_CMD: begin
          if (accept_s) begin
            tx_r     <= {cmd_data[6:0], 1'b0};
            spi_mosi <= cmd_data[7];
            last_r   <= cmd_last;
            edge_r   <= 4'd0;
            state_r  <= ST_SHIFT;
          end
`ifdef CSPI_MST_WD_EN
          else if (tick_tc_s) begin
            wd_abort <= 1'b1;
            spi_mosi <= MOSI_IDLE;
            state_r  <= ST_TRAIL;
          end
`endif
        end
        ST_TRAIL: begin
          if (tick_tc_s) begin
            spi_csn <= CSN_IDLE;
            state_r <= ST_CSN_HOLD;
          end
        end
        ST_CSN_HOLD: begin
          if (tick_tc_s) state_r <= ST_IDLE;
        end
        default: begin
          spi_csn  <= CSN_IDLE;
          spi_sck  <= SCK_IDLE;
          spi_mosi <= MOSI_IDLE;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cspi_mst.sv
// Directed bench for cspi_mst with a mode-0 slave model (samples mosi on
// rising sck, shifts miso on falling sck) and a pin-timing monitor.
module tb_cspi_mst;

  localparam int HD   = 50;
  localparam int LD   = 50;
  localparam int BG   = 200;
  localparam int CG   = 100;
  localparam int WD   = 200;
  localparam int TOUT = 30000;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic [7:0] cmd_data;
  logic       cmd_last;
  logic       cmd_vld;
  logic       cmd_rdy;
  logic [7:0] rsp_q;
  logic       rsp_qvld;
  logic       busy;
  logic       wd_abort;
  logic       spi_csn;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;

  cspi_mst #(.HALF_DIV(HD), .LEAD(LD), .BYTE_GAP(BG), .CSN_GAP(CG), .WD_LIMIT(WD)) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .cmd_data (cmd_data),
    .cmd_last (cmd_last),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .rsp_q    (rsp_q),
    .rsp_qvld (rsp_qvld),
    .busy     (busy),
    .wd_abort (wd_abort),
    .spi_csn  (spi_csn),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_mis = 0;

  // Monitor / slave state
  int         cyc = 0;
  int         t_csn_fall, t_csn_rise, t_first_rise, t_rise, t_fall, t_fall8, t_wd, t_idle, t_acc;
  int         hi_min, hi_max, lo_min, lo_max, min_gap;
  int         n_rsp, n_acc, n_csn_rise, n_wd, n_overlap, n_rise_tot;
  int         slv_cnt = 0;
  logic       first_pend = 1'b0;
  logic [7:0] slv_sh = 8'hFF;
  logic [7:0] cap = 8'h00;
  logic       csn_p = 1'b1, sck_p = 1'b0, busy_p = 1'b0;
  logic [7:0] rep_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rs_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ge(input string tag, input int obs, input int lim);
    n_vec++;
    assert (obs >= lim) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected at least %0d", tag, obs, lim);
    end
  endtask

  function automatic logic [31:0] pop8(input int which);
    if (which == 0) return (rx_q.size() > 0) ? {24'h0, rx_q.pop_front()} : 32'hDEAD_BEEF;
    else            return (rs_q.size() > 0) ? {24'h0, rs_q.pop_front()} : 32'hDEAD_BEEF;
  endfunction

  task automatic clr();
    hi_min = 1000000; hi_max = 0; lo_min = 1000000; lo_max = 0; min_gap = 1000000;
    n_rsp = 0; n_acc = 0; n_csn_rise = 0; n_wd = 0; n_overlap = 0;
    t_fall8 = 0; t_wd = 0; t_idle = 0; t_acc = 0;
    rep_q.delete(); rx_q.delete(); rs_q.delete();
  endtask

  task automatic present(input logic [7:0] d, input logic l);
    @(posedge clk_sys); #1;
    cmd_data = d; cmd_last = l; cmd_vld = 1'b1;
  endtask

  task automatic wait_accept(input string tag);
    int n = 0;
    @(negedge clk_sys);
    while (!cmd_rdy && n < TOUT) begin @(negedge clk_sys); n++; end
    chk(tag, 32'(n < TOUT), 32'd1);
    @(posedge clk_sys); #1;
    cmd_vld = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk_sys);
    while (busy && n < TOUT) begin @(negedge clk_sys); n++; end
    chk(tag, 32'(n < TOUT), 32'd1);
  endtask

  // sel: 0 = rsp pulses, 1 = sck rises, 2 = watchdog pulses
  task automatic wait_cnt(input string tag, input int sel, input int target);
    int n = 0;
    int v;
    v = (sel == 0) ? n_rsp : (sel == 1) ? n_rise_tot : n_wd;
    while (v < target && n < TOUT) begin
      @(negedge clk_sys); n++;
      v = (sel == 0) ? n_rsp : (sel == 1) ? n_rise_tot : n_wd;
    end
    chk(tag, 32'(n < TOUT), 32'd1);
  endtask

  // Slave model and pin-timing monitor, sampled on the inactive clock edge.
  initial begin
    spi_miso = 1'b1;
    forever begin
      @(negedge clk_sys);
      cyc++;
      if (csn_p && !spi_csn) begin
        t_csn_fall = cyc; slv_cnt = 0; first_pend = 1'b1;
        slv_sh = (rep_q.size() > 0) ? rep_q.pop_front() : 8'hFF;
        spi_miso = slv_sh[7];
      end
      if (!csn_p && spi_csn) begin
        t_csn_rise = cyc; n_csn_rise++; slv_cnt = 0;
      end
      if (!sck_p && spi_sck) begin
        if (first_pend) begin
          t_first_rise = cyc; first_pend = 1'b0;
        end else if (slv_cnt == 0) begin
          if (cyc - t_fall8 < min_gap) min_gap = cyc - t_fall8;
        end else begin
          if (cyc - t_fall < lo_min) lo_min = cyc - t_fall;
          if (cyc - t_fall > lo_max) lo_max = cyc - t_fall;
        end
        t_rise = cyc; n_rise_tot++;
        cap = {cap[6:0], spi_mosi};
        slv_cnt++;
        if (slv_cnt == 8) rx_q.push_back(cap);
      end
      if (sck_p && !spi_sck) begin
        if (cyc - t_rise < hi_min) hi_min = cyc - t_rise;
        if (cyc - t_rise > hi_max) hi_max = cyc - t_rise;
        t_fall = cyc;
        if (slv_cnt == 8) begin
          t_fall8 = cyc; slv_cnt = 0;
          slv_sh = (rep_q.size() > 0) ? rep_q.pop_front() : 8'hFF;
        end else begin
          slv_sh = {slv_sh[6:0], 1'b0};
        end
        spi_miso = slv_sh[7];
      end
      if (rsp_qvld) begin
        rs_q.push_back(rsp_q); n_rsp++;
        if (cmd_rdy) n_overlap++;
      end
      if (wd_abort) begin n_wd++; t_wd = cyc; end
      if (busy_p && !busy) t_idle = cyc;
      if (cmd_vld && cmd_rdy && rst_n) begin n_acc++; t_acc = cyc; end
      csn_p = spi_csn; sck_p = spi_sck; busy_p = busy;
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int r0;
    rst_n = 1'b0; cmd_vld = 1'b0; cmd_data = 8'h00; cmd_last = 1'b0;
    clr();
    repeat (3) @(negedge clk_sys);
    chk("rst_csn",   32'(spi_csn),  32'd1);
    chk("rst_sck",   32'(spi_sck),  32'd0);
    chk("rst_mosi",  32'(spi_mosi), 32'd1);
    chk("rst_rsp_q", 32'(rsp_q),    32'h00);
    chk("rst_qvld",  32'(rsp_qvld), 32'd0);
    chk("rst_wd",    32'(wd_abort), 32'd0);
    chk("rst_rdy",   32'(cmd_rdy),  32'd1);
    chk("rst_busy",  32'(busy),     32'd0);
    #2 rst_n = 1'b1;

    // Single byte A5, slave replies 3C; sck timing
    clr();
    rep_q.push_back(8'h3C);
    present(8'hA5, 1'b1);
    wait_accept("t1_accept");
    wait_idle("t1_idle");
    chk("t1_mosi_byte",  pop8(0), 32'hA5);
    chk("t1_rsp_q",      pop8(1), 32'h3C);
    chk("t1_rsp_pulses", 32'(n_rsp), 32'd1);
    chk("t1_csn_rises",  32'(n_csn_rise), 32'd1);
    chk("t1_csn_after_fall8", 32'(t_csn_rise - t_fall8), 32'(HD));
    chk("t1_first_rise", 32'(t_first_rise - t_csn_fall), 32'(LD + HD));
    chk("t1_hi_min", 32'(hi_min), 32'(HD));
    chk("t1_hi_max", 32'(hi_max), 32'(HD));
    chk("t1_lo_min", 32'(lo_min), 32'(HD));
    chk("t1_lo_max", 32'(lo_max), 32'(HD));
    chk("t1_csn_gap", 32'(t_idle - t_csn_rise), 32'(CG));

    // Burst 01,02,03 with cmd_vld held high through SHIFT/GAP
    clr();
    rep_q.push_back(8'hC1); rep_q.push_back(8'h96); rep_q.push_back(8'h7E);
    present(8'h01, 1'b0);
    wait_accept("t2_acc1");
    cmd_data = 8'h02; cmd_last = 1'b0; cmd_vld = 1'b1;
    repeat (300) @(negedge clk_sys);
    chk("t6_rdy_in_shift", 32'(cmd_rdy), 32'd0);
    chk("t6_no_extra_acc", 32'(n_acc), 32'd1);
    wait_accept("t2_acc2");
    chk("t6_acc2_first_wait", 32'(t_acc - t_fall8), 32'(BG));
    cmd_data = 8'h03; cmd_last = 1'b1; cmd_vld = 1'b1;
    wait_accept("t2_acc3");
    chk("t6_acc3_first_wait", 32'(t_acc - t_fall8), 32'(BG));
    wait_idle("t2_idle");
    chk("t2_mosi0", pop8(0), 32'h01);
    chk("t2_mosi1", pop8(0), 32'h02);
    chk("t2_mosi2", pop8(0), 32'h03);
    chk("t2_rsp0",  pop8(1), 32'hC1);
    chk("t2_rsp1",  pop8(1), 32'h96);
    chk("t2_rsp2",  pop8(1), 32'h7E);
    chk("t2_rsp_pulses", 32'(n_rsp), 32'd3);
    chk("t2_csn_rises",  32'(n_csn_rise), 32'd1);
    chk("t2_accepts",    32'(n_acc), 32'd3);
    chk_ge("t2_byte_gap", min_gap, BG);
    chk("t2_qvld_vs_rdy", 32'(n_overlap), 32'd0);

`ifdef CSPI_MST_WD_EN
    // Watchdog abort in WAIT_CMD
    clr();
    rep_q.push_back(8'h88);
    present(8'h11, 1'b0);
    wait_accept("t4_acc");
    wait_cnt("t4_wd_wait", 2, 1);
    chk("t4_wd_time", 32'(t_wd - t_fall8), 32'(BG + WD));
    wait_idle("t4_idle");
    chk("t4_csn_after_wd", 32'(t_csn_rise - t_wd), 32'(HD));
    chk("t4_idle_after_csn", 32'(t_idle - t_csn_rise), 32'(CG));
    chk("t4_wd_pulses", 32'(n_wd), 32'd1);
    chk("t4_rsp_pulses", 32'(n_rsp), 32'd1);
`else
    // Long stall in WAIT_CMD, then resume
    clr();
    rep_q.push_back(8'h88); rep_q.push_back(8'h44);
    present(8'h11, 1'b0);
    wait_accept("t4_acc1");
    wait_cnt("t4_rsp_wait", 0, 1);
    repeat (BG + 10) @(negedge clk_sys);
    r0 = n_rise_tot;
    repeat (5000) @(negedge clk_sys);
    chk("t4_csn_low",  32'(spi_csn), 32'd0);
    chk("t4_sck_low",  32'(spi_sck), 32'd0);
    chk("t4_no_rsp",   32'(n_rsp), 32'd1);
    chk("t4_no_sck",   32'(n_rise_tot - r0), 32'd0);
    chk("t4_busy",     32'(busy), 32'd1);
    chk("t4_rdy",      32'(cmd_rdy), 32'd1);
    present(8'h22, 1'b1);
    wait_accept("t4_acc2");
    wait_idle("t4_idle");
    chk("t4_mosi0", pop8(0), 32'h11);
    chk("t4_mosi1", pop8(0), 32'h22);
    chk("t4_rsp0",  pop8(1), 32'h88);
    chk("t4_rsp1",  pop8(1), 32'h44);
    chk("t4_no_wd", 32'(n_wd), 32'd0);
`endif

    // Reset after the 3rd sck rise, then a clean transaction
    clr();
    rep_q.push_back(8'h99);
    present(8'hC3, 1'b1);
    wait_accept("t5_acc1");
    wait_cnt("t5_rise_wait", 1, n_rise_tot + 3);
    repeat (10) @(negedge clk_sys);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_csn_async",  32'(spi_csn),  32'd1);
    chk("t5_sck_async",  32'(spi_sck),  32'd0);
    chk("t5_mosi_async", 32'(spi_mosi), 32'd1);
    chk("t5_rsp_q_rst",  32'(rsp_q),    32'h00);
    repeat (3) @(negedge clk_sys);
    #2 rst_n = 1'b1;
    repeat (900) @(negedge clk_sys);
    chk("t5_no_partial_rsp", 32'(n_rsp), 32'd0);
    clr();
    rep_q.push_back(8'hA7);
    present(8'h5A, 1'b1);
    wait_accept("t5_acc2");
    wait_idle("t5_idle");
    chk("t5_mosi", pop8(0), 32'h5A);
    chk("t5_rsp",  pop8(1), 32'hA7);
    chk("t5_rsp_pulses", 32'(n_rsp), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
